// File: rtl/fir_sched_pkg.sv
// Shared constants for the FIR band scheduler: default sizes, FSM state codes
// and the band slice helper used for packed per-band buses.

`ifndef FIR_BAND_SLICE
`define FIR_BAND_SLICE(vec, b, dw) vec[(b)*(dw) +: (dw)]
`endif

package fir_sched_pkg;

   localparam int NBANDS_D  = 4;
   localparam int DW_D      = 10;
   localparam int TIMEOUT_D = 255;
   localparam int TW_D      = 8;
   localparam int CLR_CYC_D = 2;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LAUNCH = 3'd1;
   localparam logic [2:0] WAIT   = 3'd2;
   localparam logic [2:0] HOLD   = 3'd3;
   localparam logic [2:0] CLEAR  = 3'd4;

endpackage

// File: rtl/fir_band_capture.sv
// Per-band result capture: edge-detects the band's result-available level and
// loads the result once per sample. A repeat edge never overwrites the first result.

module fir_band_capture
   import fir_sched_pkg::*;
#(
   parameter int DW = DW_D
) (
   input  logic          clk_fast,
   input  logic          rst_n,
   input  logic          avl,
   input  logic [DW-1:0] dout,
   input  logic          arm,
   input  logic          clr,
   output logic          done,
   output logic          hit,
   output logic [DW-1:0] res
);

   logic          avl_q;
   logic          done_q;
   logic [DW-1:0] res_q;

   // Edge only counts while the band is armed and has not yet delivered.
   assign hit  = arm & avl & ~avl_q & ~done_q;
   assign done = done_q;
   assign res  = res_q;

   // Track the previous level continuously so edges outside WAIT are consumed.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) avl_q <= 1'b0;
      else        avl_q <= avl;
   end

   // Load-once result register with its done flag.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
         res_q  <= '0;
      end else if (clr) begin
         done_q <= 1'b0;
         res_q  <= '0;
      end else if (hit) begin
         done_q <= 1'b1;
         res_q  <= dout;
      end
   end

endmodule

// File: rtl/fir_band_scheduler.sv
// Sequences NBANDS FIR band filters for one sample at a time: accept, broadcast,
// pulse enables, collect results with a watchdog, and hand the result word on.
//
//  state  | meaning
//  IDLE   | ready for a sample; services pending flush first
//  LAUNCH | one-cycle band_en pulse, clears per-sample state
//  WAIT   | collecting band results, watchdog running
//  HOLD   | result word presented until out_ready
//  CLEAR  | band_clr asserted for CLR_CYC cycles

module fir_band_scheduler
   import fir_sched_pkg::*;
#(
   parameter int NBANDS  = NBANDS_D,
   parameter int DW      = DW_D,
   parameter int TIMEOUT = TIMEOUT_D,
   parameter int TW      = TW_D,
   parameter int CLR_CYC = CLR_CYC_D
) (
   input  logic                 clk_fast,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [DW-1:0]        in_data,
   output logic                 in_ready,
   input  logic [NBANDS-1:0]    band_mask,
   input  logic                 flush,
   output logic [DW-1:0]        band_din,
   output logic [NBANDS-1:0]    band_en,
   output logic                 band_clr,
   input  logic [NBANDS-1:0]    band_avl,
   input  logic [NBANDS*DW-1:0] band_dout,
   output logic                 out_valid,
   output logic [NBANDS*DW-1:0] out_data,
   input  logic                 out_ready,
   output logic [NBANDS-1:0]    out_err,
   output logic                 busy,
   output logic [15:0]          sample_cnt
);

   localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

   logic [2:0]           state, state_nx;
   logic [NBANDS-1:0]    mask_q, err_q, done_v, hit_v;
   logic [TW-1:0]        timer;
   logic [CW-1:0]        clr_cnt;
   logic                 flush_pend, accept, all_done, tmo, cap_clr;
   logic [NBANDS*DW-1:0] res_v;

   assign accept   = (state == IDLE) & in_valid & in_ready;
   assign all_done = &(done_v | hit_v | ~mask_q);
   assign tmo      = (timer == '0);
   assign cap_clr  = accept | (state == LAUNCH) | (state == CLEAR);

   for (genvar b = 0; b < NBANDS; b++) begin : g_band
      fir_band_capture #(.DW(DW)) u_cap (
         .clk_fast (clk_fast),
         .rst_n    (rst_n),
         .avl      (band_avl[b]),
         .dout     (`FIR_BAND_SLICE(band_dout, b, DW)),
         .arm      ((state == WAIT) & mask_q[b]),
         .clr      (cap_clr),
         .done     (done_v[b]),
         .hit      (hit_v[b]),
         .res      (`FIR_BAND_SLICE(res_v, b, DW))
      );
   end

   // State register.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state decode; flush beats a simultaneous sample, completion beats timeout.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (flush | flush_pend)  state_nx = CLEAR;
                  else if (accept)         state_nx = (band_mask == '0) ? HOLD : LAUNCH;
         LAUNCH:  state_nx = WAIT;
         WAIT:    if (all_done | tmo)      state_nx = HOLD;
         HOLD:    if (out_ready)           state_nx = IDLE;
         CLEAR:   if (clr_cnt == '0)       state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs decoded straight from state so reset drops them immediately.
   always_comb begin
      in_ready  = (state == IDLE) & ~flush & ~flush_pend;
      band_en   = (state == LAUNCH) ? mask_q : '0;
      band_clr  = (state == CLEAR);
      out_valid = (state == HOLD);
      busy      = (state != IDLE);
      out_data  = res_v;
      out_err   = err_q;
   end

   // Sample and mask captured at accept.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         band_din <= '0;
         mask_q   <= '0;
      end else if (accept) begin
         band_din <= in_data;
         mask_q   <= band_mask;
      end
   end

   // Watchdog down-counter; reaching zero marks the last allowed WAIT cycle.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n)                      timer <= '0;
      else if (state == LAUNCH)        timer <= TW'(TIMEOUT - 1);
      else if (state == WAIT && !tmo)  timer <= timer - 1'b1;
   end

   // Missing-band flags, latched only when the watchdog expires first.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n)                                  err_q <= '0;
      else if (accept)                             err_q <= '0;
      else if (state == WAIT && tmo && !all_done)  err_q <= mask_q & ~(done_v | hit_v);
   end

   // Flush arriving mid-sample is remembered until the next IDLE.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n)                        flush_pend <= 1'b0;
      else if (state == CLEAR)           flush_pend <= 1'b0;
      else if (flush && state != IDLE)   flush_pend <= 1'b1;
   end

   // Clear-duration down-counter, preloaded whenever not clearing.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n)                 clr_cnt <= CW'(CLR_CYC - 1);
      else if (state != CLEAR)    clr_cnt <= CW'(CLR_CYC - 1);
      else if (clr_cnt != '0)     clr_cnt <= clr_cnt - 1'b1;
   end

   // Delivered-sample counter, wraps naturally.
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n)                         sample_cnt <= '0;
      else if (state == HOLD && out_ready) sample_cnt <= sample_cnt + 16'd1;
   end

endmodule

// File: tb/tb_fir_band_scheduler.sv
// Directed plus randomized bench for fir_band_scheduler with a transaction-level model.

module tb_fir_band_scheduler;

   localparam int NB  = 4;
   localparam int DW  = 10;
   localparam int TMO = 255;

   logic             clk_fast = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic [DW-1:0]    in_data = '0;
   logic [NB-1:0]    band_mask = '0;
   logic             flush = 1'b0;
   logic [NB-1:0]    band_avl = '0;
   logic [NB*DW-1:0] band_dout = '0;
   logic             out_ready = 1'b0;
   logic             in_ready, band_clr, out_valid, busy;
   logic [DW-1:0]    band_din;
   logic [NB-1:0]    band_en, out_err;
   logic [NB*DW-1:0] out_data;
   logic [15:0]      sample_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] cnt_model = '0;
   int          dly [NB];
   logic [DW-1:0] res [NB];

   always #5 clk_fast = ~clk_fast;

   fir_band_scheduler dut (
      .clk_fast   (clk_fast),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .band_mask  (band_mask),
      .flush      (flush),
      .band_din   (band_din),
      .band_en    (band_en),
      .band_clr   (band_clr),
      .band_avl   (band_avl),
      .band_dout  (band_dout),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .out_err    (out_err),
      .busy       (busy),
      .sample_cnt (sample_cnt)
   );

   task automatic tick;
      @(posedge clk_fast);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_dly(input int a, input int b, input int c, input int d);
      dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d;
   endtask

   task automatic new_res;
      for (int b = 0; b < NB; b++) res[b] = DW'($urandom);
   endtask

   // Band behaviour: delay 0 means level already high (no edge); otherwise avl rises
   // d cycles after the enable cycle, and the result is valid only on that cycle.
   task automatic drive_bands(input int c);
      for (int b = 0; b < NB; b++) begin
         band_avl[b] = (dly[b] == 0) || (c >= dly[b]);
         band_dout[b*DW +: DW] = (c == dly[b]) ? res[b] : DW'($urandom);
      end
   endtask

   task automatic do_sample(input logic [NB-1:0] mask, input logic [DW-1:0] data,
                            input int hold, input int flush_at);
      logic [NB*DW-1:0] exp_data;
      logic [NB-1:0]    exp_err;
      int maxd, vcyc;
      exp_data = '0;
      exp_err  = '0;
      maxd     = 0;
      for (int b = 0; b < NB; b++) begin
         if (mask[b]) begin
            if (dly[b] >= 1 && dly[b] <= TMO) begin
               exp_data[b*DW +: DW] = res[b];
               if (dly[b] > maxd) maxd = dly[b];
            end else begin
               exp_err[b] = 1'b1;
            end
         end
      end
      vcyc = (mask == '0) ? 0 : ((exp_err != '0) ? TMO + 1 : maxd + 1);

      chk("in_ready_idle", in_ready, 1);
      chk("busy_idle", busy, 0);
      in_valid  = 1'b1;
      in_data   = data;
      band_mask = mask;
      drive_bands(-1);
      tick;
      in_valid  = 1'b0;
      in_data   = DW'($urandom);
      band_mask = NB'($urandom);

      for (int c = 0; c <= vcyc; c++) begin
         chk("out_valid_timing", out_valid, (c == vcyc));
         if (c == 0) begin
            chk("band_en_pulse", band_en, mask);
            chk("band_din", band_din, data);
         end else if (c == 1) begin
            chk("band_en_single", band_en, 0);
         end
         if (c == vcyc) break;
         flush = (c == flush_at);
         drive_bands(c);
         tick;
      end
      flush = 1'b0;

      for (int h = 0; h <= hold; h++) begin
         chk("hold_valid", out_valid, 1);
         chk("out_data", out_data, exp_data);
         chk("out_err", out_err, exp_err);
         chk("hold_in_ready", in_ready, 0);
         if (h < hold) tick;
      end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      cnt_model = cnt_model + 16'd1;
      chk("handoff_valid", out_valid, 0);
      chk("sample_cnt", sample_cnt, cnt_model);

      if (flush_at >= 0 && flush_at < vcyc) begin
         chk("pend_in_ready", in_ready, 0);
         chk("pend_clr", band_clr, 0);
         tick;
         chk("clr_cyc1", band_clr, 1);
         chk("clr_in_ready1", in_ready, 0);
         tick;
         chk("clr_cyc2", band_clr, 1);
         chk("clr_in_ready2", in_ready, 0);
         tick;
         chk("clr_done", band_clr, 0);
         chk("clr_cnt_kept", sample_cnt, cnt_model);
      end else begin
         chk("back_idle", in_ready, 1);
      end
   endtask

   initial begin
      tick;
      tick;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_band_en", band_en, 0);
      chk("rst_band_clr", band_clr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_sample_cnt", sample_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      tick;

      // Full mask, staggered responses
      new_res; set_dly(5, 7, 9, 12);
      do_sample(4'hF, 10'h155, 0, -1);

      // Partial mask; unmasked bands still toggle
      new_res; set_dly(3, 4, 6, 2);
      do_sample(4'b0101, DW'($urandom), 0, -1);

      // Band 2 never answers
      new_res; set_dly(4, 6, 300, 8);
      do_sample(4'hF, DW'($urandom), 0, -1);

      // Back-pressure for 20 cycles
      new_res; set_dly(3, 9, 2, 5);
      do_sample(4'hF, DW'($urandom), 20, -1);

      // Flush during WAIT
      new_res; set_dly(2, 5, 6, 7);
      do_sample(4'hF, DW'($urandom), 1, 3);

      // Completion on the very last watchdog cycle wins
      new_res; set_dly(255, 3, 3, 3);
      do_sample(4'hF, DW'($urandom), 0, -1);

      // One cycle too late
      new_res; set_dly(256, 3, 3, 3);
      do_sample(4'b1001, DW'($urandom), 0, -1);

      // Empty mask goes straight to HOLD with zero results
      new_res; set_dly(2, 2, 2, 2);
      do_sample(4'h0, DW'($urandom), 1, -1);

      // Flush and in_valid together in IDLE
      flush = 1'b1; in_valid = 1'b1; band_mask = 4'hF; in_data = DW'($urandom);
      #1;
      chk("flush_blocks_ready", in_ready, 0);
      tick;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_wins_clr", band_clr, 1);
      chk("flush_wins_en", band_en, 0);
      tick;
      chk("flush_clr2", band_clr, 1);
      tick;
      chk("flush_end", band_clr, 0);
      chk("flush_ready", in_ready, 1);
      chk("flush_cnt", sample_cnt, cnt_model);

      // Randomized samples
      for (int n = 0; n < 25; n++) begin
         int r, hold, fat;
         new_res;
         for (int b = 0; b < NB; b++) begin
            r = int'($urandom_range(0, 15));
            dly[b] = (r == 0) ? 0 : (r == 1) ? 400 : int'($urandom_range(1, 30));
         end
         hold = int'($urandom_range(0, 3));
         fat  = ($urandom_range(0, 4) == 0) ? 1 : -1;
         do_sample(NB'($urandom), DW'($urandom), hold, fat);
      end

      // Reset in the middle of a launch
      new_res; band_avl = '0;
      band_mask = 4'hF; in_valid = 1'b1; in_data = DW'($urandom);
      tick;
      in_valid = 1'b0;
      chk("pre_rst_en", band_en, 4'hF);
      band_avl = 4'hF;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_band_en", band_en, 0);
      chk("arst_band_clr", band_clr, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_out_err", out_err, 0);
      chk("arst_cnt", sample_cnt, 0);
      cnt_model = '0;
      tick;
      rst_n = 1'b1;
      tick;
      tick;
      // Stale high levels must not produce results
      set_dly(0, 0, 0, 0);
      do_sample(4'hF, DW'($urandom), 0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
